// File: rtl/frame_sequencer.sv
// frame_sequencer: frames one image with zero pad rows into the core, then counts result beats to completion or drain timeout.
module frame_sequencer #(
    parameter int IMG_W         = 512,
    parameter int IMG_H         = 512,
    parameter int PAD_ROWS      = 1,
    parameter int PIX_W         = 8,
    parameter int OUT_PIXELS    = 262144,
    parameter int DRAIN_TIMEOUT = 65535
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_start,
    input  logic                                    i_abort,
    input  logic                                    i_src_valid,
    input  logic [PIX_W-1:0]                        i_src_data,
    output logic                                    o_src_ready,
    output logic [PIX_W-1:0]                        o_pixel_data,
    output logic                                    o_pixel_data_valid,
    input  logic                                    i_core_ready,
    input  logic                                    i_res_valid,
    input  logic                                    i_res_ready,
    output logic                                    o_busy,
    output logic [$clog2(IMG_H+2*PAD_ROWS+1)-1:0]   o_row,
    output logic                                    o_frame_done,
    output logic                                    o_error
);
    localparam int ROW_W = $clog2(IMG_H + 2*PAD_ROWS + 1);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RES_W = $clog2(OUT_PIXELS + 1);
    localparam int TO_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
    localparam logic [ROW_W-1:0] TOP_LAST = ROW_W'(PAD_ROWS - 1);
    localparam logic [ROW_W-1:0] SRC_LAST = ROW_W'(PAD_ROWS + IMG_H - 1);
    localparam logic [ROW_W-1:0] BOT_LAST = ROW_W'(2*PAD_ROWS + IMG_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_PAD_TOP, S_STREAM, S_PAD_BOT, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [RES_W-1:0]   r_res;
    logic [TO_W-1:0]    r_idle;
    logic               w_pad, w_stream, w_core_xfer, w_row_end, w_res_beat, w_res_full, w_timeout, w_start;

    assign w_pad       = (r_state == S_PAD_TOP) || (r_state == S_PAD_BOT);
    assign w_stream    = r_state == S_STREAM;
    assign o_busy      = r_state != S_IDLE;
    assign o_pixel_data_valid = w_pad || (w_stream && i_src_valid);
    assign o_pixel_data       = (w_stream && i_src_valid) ? i_src_data : '0;
    assign o_src_ready = w_stream && i_core_ready;
    assign o_row       = r_row;
    assign w_core_xfer = o_pixel_data_valid && i_core_ready;
    assign w_row_end   = w_core_xfer && (r_col == COL_W'(IMG_W - 1));
    assign w_res_beat  = o_busy && i_res_valid && i_res_ready;
    assign w_res_full  = r_res == RES_W'(OUT_PIXELS);
    // The cycle that completes DRAIN_TIMEOUT idle cycles is itself the error cycle.
    assign w_timeout   = (r_state == S_DRAIN) && !w_res_full && !w_res_beat && (r_idle == TO_W'(DRAIN_TIMEOUT - 1));
    assign w_start     = (r_state == S_IDLE) && i_start && !i_abort;
    assign o_error     = w_timeout && !i_abort;
    assign o_frame_done = (r_state == S_DONE) && !i_abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = i_start ? ((PAD_ROWS > 0) ? S_PAD_TOP : S_STREAM) : S_IDLE;
            S_PAD_TOP: w_next = (w_row_end && r_row == TOP_LAST) ? S_STREAM : S_PAD_TOP;
            S_STREAM:  w_next = (w_row_end && r_row == SRC_LAST) ? ((PAD_ROWS > 0) ? S_PAD_BOT : S_DRAIN) : S_STREAM;
            S_PAD_BOT: w_next = (w_row_end && r_row == BOT_LAST) ? S_DRAIN : S_PAD_BOT;
            S_DRAIN:   w_next = w_res_full ? S_DONE : (w_timeout ? S_IDLE : S_DRAIN);
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (i_abort) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_res   <= '0;
            r_idle  <= '0;
        end else begin
            r_state <= w_next;
            r_idle  <= (r_state != S_DRAIN || w_res_beat) ? '0 : r_idle + 1'b1;
            if (w_start) begin
                r_col <= '0;
                r_row <= '0;
                r_res <= '0;
            end else begin
                if (w_core_xfer) r_col <= w_row_end ? '0 : r_col + 1'b1;
                if (w_row_end) r_row <= r_row + 1'b1;
                if (w_res_beat && !w_res_full) r_res <= r_res + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed checks of a padded (A) and an unpadded (B) frame_sequencer on a 4x3 image.
module tb_frame_sequencer;
    localparam int W = 4, H = 3, PW = 8, OUT = 12, TO = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b, abort, src_valid, core_ready, res_valid, res_ready;
    logic [PW-1:0] src_data;
    logic a_src_ready, a_pvalid, a_busy, a_done, a_err;
    logic [PW-1:0] a_pdata;
    logic [2:0] a_row;
    logic b_src_ready, b_pvalid, b_busy, b_done, b_err;
    logic [PW-1:0] b_pdata;
    logic [1:0] b_row;

    frame_sequencer #(.IMG_W(W), .IMG_H(H), .PAD_ROWS(1), .PIX_W(PW), .OUT_PIXELS(OUT), .DRAIN_TIMEOUT(TO)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_abort(abort),
        .i_src_valid(src_valid), .i_src_data(src_data), .o_src_ready(a_src_ready),
        .o_pixel_data(a_pdata), .o_pixel_data_valid(a_pvalid), .i_core_ready(core_ready),
        .i_res_valid(res_valid), .i_res_ready(res_ready), .o_busy(a_busy), .o_row(a_row),
        .o_frame_done(a_done), .o_error(a_err));

    frame_sequencer #(.IMG_W(W), .IMG_H(H), .PAD_ROWS(0), .PIX_W(PW), .OUT_PIXELS(OUT), .DRAIN_TIMEOUT(TO)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_abort(abort),
        .i_src_valid(src_valid), .i_src_data(src_data), .o_src_ready(b_src_ready),
        .o_pixel_data(b_pdata), .o_pixel_data_valid(b_pvalid), .i_core_ready(core_ready),
        .i_res_valid(res_valid), .i_res_ready(res_ready), .o_busy(b_busy), .o_row(b_row),
        .o_frame_done(b_done), .o_error(b_err));

    int n_chk = 0, n_pass = 0;
    int cyc_n = 0, start_cyc, first_a, last_a, first_b, last_b;
    int done_a, done_b, err_a, err_b, viol, src_idx, res_left, last_res_cyc, err_cyc;
    bit core_toggle, src_rand, res_late;
    logic [PW-1:0] a_q[$], b_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        bit took;
        @(negedge clk);
        if (a_src_ready && (a_q.size() < W || a_q.size() >= W + W*H)) viol++;
        if (a_pvalid && core_ready) begin
            if (a_q.size() == 0) first_a = cyc_n;
            last_a = cyc_n;
            a_q.push_back(a_pdata);
        end
        if (b_pvalid && core_ready) begin
            if (b_q.size() == 0) first_b = cyc_n;
            last_b = cyc_n;
            b_q.push_back(b_pdata);
        end
        took = src_valid && (a_src_ready || b_src_ready);
        if (res_valid && res_ready && (a_busy || b_busy)) begin
            res_left--;
            last_res_cyc = cyc_n;
        end
        if (a_done) done_a++;
        if (b_done) done_b++;
        if (b_err) err_b++;
        if (a_err) begin
            err_a++;
            err_cyc = cyc_n;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (took) src_idx++;
        src_valid  = src_rand ? 1'($urandom_range(1)) : 1'b1;
        src_data   = PW'(src_idx + 1);
        core_ready = core_toggle ? ~core_ready : 1'b1;
        res_valid  = res_left > 0 && (!res_late || a_q.size() >= 2*W + W*H);
    endtask

    task automatic prep(input bit tog, input bit rnd, input int res_n, input bit late);
        a_q.delete();
        b_q.delete();
        {done_a, done_b, err_a, err_b, viol, src_idx} = '0;
        first_a = -1; last_a = -1; first_b = -1; last_b = -1; last_res_cyc = -1; err_cyc = -1;
        core_toggle = tog; src_rand = rnd; res_left = res_n; res_late = late;
        src_valid = 1'b1; src_data = 8'd1; core_ready = 1'b1; res_ready = 1'b1;
        res_valid = res_n > 0 && !late;
    endtask

    task automatic go(input bit use_b);
        start_cyc = cyc_n;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while ((a_busy || b_busy) && n < max) begin
            cyc();
            n++;
        end
        check({tag, "_finished"}, int'(a_busy || b_busy), 0);
    endtask

    task automatic check_seq(input string tag, input bit use_b);
        int pad = use_b ? 0 : W;
        int total = use_b ? W*H : 2*W + W*H;
        int errs = 0;
        int n = use_b ? b_q.size() : a_q.size();
        for (int i = 0; i < n; i++) begin
            int exp = (i < pad || i >= pad + W*H) ? 0 : i - pad + 1;
            int got = use_b ? int'(b_q[i]) : int'(a_q[i]);
            if (got != exp) errs++;
        end
        check({tag, "_beats"}, n, total);
        check({tag, "_order"}, errs, 0);
    endtask

    task automatic check_frame(input string tag);
        check_seq(tag, 1'b0);
        check({tag, "_done"}, done_a, 1);
        check({tag, "_err"}, err_a, 0);
        check({tag, "_row"}, int'(a_row), 5);
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        prep(1'b0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(a_busy), 0);
        check("rst_pvalid", int'(a_pvalid), 0);
        check("rst_src_ready", int'(a_src_ready), 0);
        check("rst_pdata", int'(a_pdata), 0);
        check("rst_row", int'(a_row), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_err", int'(a_err), 0);
        rst = 1'b0;
        cyc();

        prep(1'b0, 1'b0, OUT, 1'b0);
        go(1'b0);
        wait_idle("full", 60);
        check("full_first", first_a - start_cyc, 1);
        check("full_span", last_a - first_a, 2*W + W*H - 1);
        check_frame("full");

        prep(1'b1, 1'b1, OUT, 1'b0);
        go(1'b0);
        wait_idle("toggle", 400);
        check_frame("toggle");
        check("toggle_src_ready_outside_stream", viol, 0);

        prep(1'b0, 1'b0, OUT - 1, 1'b1);
        go(1'b0);
        wait_idle("timeout", 100);
        check("timeout_results", res_left, 0);
        check("timeout_err", err_a, 1);
        check("timeout_done", done_a, 0);
        check("timeout_delay", err_cyc - last_res_cyc, TO);

        prep(1'b0, 1'b0, OUT, 1'b0);
        go(1'b0);
        for (int n = 0; n < 50 && a_q.size() < 2*W + 1; n++) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_pvalid", int'(a_pvalid), 0);
        check("abort_src_ready", int'(a_src_ready), 0);
        check("abort_busy", int'(a_busy), 0);
        check("abort_row_hold", int'(a_row), 2);
        repeat (3) cyc();
        check("abort_no_done", done_a, 0);
        prep(1'b0, 1'b0, OUT, 1'b0);
        go(1'b0);
        wait_idle("restart", 60);
        check("restart_first", first_a - start_cyc, 1);
        check_frame("restart");

        prep(1'b0, 1'b0, OUT, 1'b0);
        start_a = 1'b1;
        abort = 1'b1;
        cyc();
        start_a = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", int'(a_busy), 0);
        prep(1'b0, 1'b0, OUT, 1'b0);
        go(1'b0);
        for (int n = 0; n < 50 && a_q.size() < W + 2; n++) cyc();
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        wait_idle("busy_start", 60);
        check("busy_start_first", first_a - start_cyc, 1);
        check("busy_start_span", last_a - first_a, 2*W + W*H - 1);
        check_frame("busy_start");

        prep(1'b0, 1'b0, OUT, 1'b0);
        go(1'b1);
        wait_idle("nopad", 60);
        check_seq("nopad", 1'b1);
        check("nopad_first", first_b - start_cyc, 1);
        check("nopad_span", last_b - first_b, W*H - 1);
        check("nopad_done", done_b, 1);
        check("nopad_err", err_b, 0);
        check("nopad_row", int'(b_row), H);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
